// File: rtl/data_memory.sv
// Line-oriented 128-bit data memory behind the data cache.
// Whole-line reads/writes complete after a fixed LATENCY via busywait.
module data_memory #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read,
    input  logic          write,
    input  logic [31:0]   address,
    input  logic [127:0]  writedata,
    output logic [127:0]  readdata,
    output logic          busywait
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   op_wr_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [127:0]           wdata_q;
    logic [127:0]           readdata_q;
    logic [127:0]           mem_q [DEPTH] = '{default: '0};

    logic commit;
    logic unused_addr;

    assign unused_addr = ^address[31:ADDR_BITS];
    assign commit      = (state_q == ACCESS) && (cnt_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (write || read) begin
                        op_wr_q <= write;
                        idx_q   <= address[ADDR_BITS-1:0];
                        wdata_q <= writedata;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!op_wr_q) begin
                            readdata_q <= mem_q[idx_q];
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (!reset && commit && op_wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign readdata = readdata_q;
    assign busywait = ((state_q == IDLE) && (read || write))
                    || (state_q == ACCESS);

endmodule

// File: doc/data_memory.md
# data_memory

Line-oriented data memory that serves the data cache's refill and write-back requests. Stores DEPTH lines of 128 bits, accepts one whole-line read or write at a time over a level-held request/busywait handshake, and completes each access after a fixed, parameterised latency. Sits directly below the data cache on its memory-side port.

## Interface

- DEPTH, 256: number of 128-bit lines; power of two.
- ADDR_BITS, 8: log2(DEPTH); line index width.
- LATENCY, 4: number of ACCESS cycles per request; integer ≥ 1.
- clock  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- read  input  1  line-read request; held high until completion is observed.
- write  input  1  line-write request; held high until completion is observed.
- address  input  32  line address (the cache's {tag, index}); only address[ADDR_BITS-1:0] is used.
- writedata  input  128  line to store; sampled at request acceptance.
- readdata  output  128  registered line from the most recent completed read.
- busywait  output  1  high while a request is pending or in progress; low signals completion.

## Operation

- States: IDLE, ACCESS, DONE. Counter cnt, width ≥ clog2(LATENCY).
- IDLE: if write or read at posedge → latch op (write wins if both high), line index = address[ADDR_BITS-1:0], writedata; load cnt = LATENCY-1; go ACCESS. Otherwise stay.
- ACCESS: if cnt == 0 at posedge → perform the access, go DONE; else cnt -= 1. Request inputs are ignored in ACCESS: deasserting read/write mid-access does not cancel it, and address/writedata changes have no effect.
- Access at ACCESS→DONE edge: write stores the latched line into mem[index]; read loads readdata <= mem[index].
- DONE: lasts exactly one cycle, then → IDLE unconditionally. The requester samples busywait == 0 at this edge and must change or drop its request.
- busywait (combinational) = (state==IDLE && (read||write)) || state==ACCESS. Low in DONE and in IDLE with no request. A request rising in IDLE therefore raises busywait in the same cycle, so the requester never sees a stale completion.
- Back-to-back: a request still or newly high when IDLE is re-entered after DONE is a new access (write-back followed by refill needs no idle gap beyond DONE).
- Simultaneous read and write: treated as a write; readdata unchanged.
- Address wrap: bits above ADDR_BITS-1 are ignored; index DEPTH aliases index 0.
- readdata is held between reads; writes never modify it.
- Array contents power up to zero (simulation initialisation); reset does not alter the array.

## Timing

- Reset: state=IDLE, cnt=0, readdata=0; busywait then follows read||write combinationally. Reset has priority over all transitions.
- Reset during ACCESS or DONE: the in-flight access is abandoned; a write not yet committed (before the ACCESS→DONE edge) is never stored.
- Latency: request seen at edge E0 (IDLE→ACCESS); commit at edge E0+LATENCY (→DONE); busywait high for LATENCY+1 cycles from the request's first cycle, low for the DONE cycle; readdata valid from the start of DONE.
- Throughput: one access per LATENCY+2 cycles with a continuously re-asserted request.

## Test plan

- Reset then read with address 0x3 (LATENCY=4) → busywait high for exactly 5 cycles, low in DONE, readdata = 0.
- Write address 0x5, writedata 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D; then read 0x5 → readdata equals that value; busywait timing identical for read and write.
- Write 0x7 = A then immediately read 0x9 (request switched in the DONE cycle) → write committed, read begins in the next IDLE, busywait goes high again with no low cycle other than DONE; readdata = mem[0x9].
- Write address 0x105 (DEPTH=256) = 0x1111…1111, read 0x05 → readdata = 0x1111…1111.
- Start a write to 0x2 = 0xFFFF…FFFF, assert reset two cycles into ACCESS → state IDLE, readdata = 0; a later read of 0x2 returns its previous contents.
- Assert read and write together to 0x4 with writedata 0x55…55 → mem[0x4] = 0x55…55, readdata keeps its prior value; dropping read mid-ACCESS does not shorten the access.
